// File: rtl/scoreboard_ctrl_if.sv
// Scoreboard bundle: game-core inputs toward the controller and the
// display/status outputs coming back from it.
interface scoreboard_ctrl_if;
   logic [7:0] runs;
   logic [3:0] wickets;
   logic       inning_over;
   logic       game_over;
   logic       winner;
   logic       disp_sel;
   logic [8:0] target;
   logic       innings;
   logic       result_valid;
   logic       bcd_busy;
   logic [3:0] an;
   logic [6:0] seg;

   // Game core / stimulus side: drives scores, watches the display
   modport master (
      output runs, wickets, inning_over, game_over, winner, disp_sel,
      input  target, innings, result_valid, bcd_busy, an, seg
   );

   // Scoreboard controller side
   modport slave (
      input  runs, wickets, inning_over, game_over, winner, disp_sel,
      output target, innings, result_valid, bcd_busy, an, seg
   );
endinterface

// File: rtl/scoreboard_ctrl.sv
// Scoreboard controller: tracks innings/target/result from the game core,
// converts the selected value to BCD with a double-dabble FSM and scans
// four multiplexed seven-segment digits (active-low an/seg).
module scoreboard_ctrl #(
   parameter int unsigned SCAN_DIV = 16
) (
   input logic          clk,
   input logic          reset,
   scoreboard_ctrl_if.slave sb
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } conv_state_t;

   localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

   // Active-low glyph for a decimal digit; non-decimal codes go blank
   function automatic logic [6:0] digit_glyph(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'd0:    g = 7'b1000000;
         4'd1:    g = 7'b1111001;
         4'd2:    g = 7'b0100100;
         4'd3:    g = 7'b0110000;
         4'd4:    g = 7'b0011001;
         4'd5:    g = 7'b0010010;
         4'd6:    g = 7'b0000010;
         4'd7:    g = 7'b1111000;
         4'd8:    g = 7'b0000000;
         4'd9:    g = 7'b0010000;
         default: g = 7'b1111111;
      endcase
      return g;
   endfunction

   // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
   function automatic logic [20:0] bcd_step(input logic [20:0] v);
      logic [20:0] a;
      a = v;
      if (a[12:9]  >= 4'd5) a[12:9]  = a[12:9]  + 4'd3;
      if (a[16:13] >= 4'd5) a[16:13] = a[16:13] + 4'd3;
      if (a[20:17] >= 4'd5) a[20:17] = a[20:17] + 4'd3;
      return {a[19:0], 1'b0};
   endfunction

   // Edge detection
   logic io_r, io_prev_r, go_r, go_prev_r;
   logic io_rise_s, go_rise_s;

   // Match state
   logic [8:0] target_r;
   logic       innings_r, rv_r, winner_r;

   // Converter
   conv_state_t state_r, state_n;
   logic [8:0]  src_s, last_r, conv_src_r;
   logic [20:0] shift_r;
   logic [3:0]  cnt_r;
   logic        busy_r;
   logic [3:0]  hund_r, tens_r, units_r;

   // Display scan
   logic [15:0] scan_cnt_r;
   logic [1:0]  digit_r;
   logic [3:0]  an_r, an_s;
   logic [6:0]  seg_r, seg_s;

   assign io_rise_s = io_r & ~io_prev_r;
   assign go_rise_s = go_r & ~go_prev_r;
   assign src_s     = sb.disp_sel ? target_r : {1'b0, sb.runs};

   // Register the level inputs once and keep the previous copy for edges
   always_ff @(posedge clk) begin
      if (!reset) begin
         io_r      <= 1'b0;
         io_prev_r <= 1'b0;
         go_r      <= 1'b0;
         go_prev_r <= 1'b0;
      end else begin
         io_r      <= sb.inning_over;
         io_prev_r <= io_r;
         go_r      <= sb.game_over;
         go_prev_r <= go_r;
      end
   end

   // Innings/target/result tracking; everything freezes once the result is in
   always_ff @(posedge clk) begin
      if (!reset) begin
         target_r  <= 9'd0;
         innings_r <= 1'b0;
         rv_r      <= 1'b0;
         winner_r  <= 1'b0;
      end else if (!rv_r) begin
         if (go_rise_s) begin
            rv_r     <= 1'b1;
            winner_r <= sb.winner;
         end else if (io_rise_s && !innings_r) begin
            target_r  <= {1'b0, sb.runs} + 9'd1;
            innings_r <= 1'b1;
         end
      end
   end

   // Converter state register; busy mirrors the state being entered
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_n;
         busy_r  <= (state_n != ST_IDLE);
      end
   end

   // Converter next-state: start whenever the source moved since last time
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_IDLE: begin
            if (src_s != last_r) state_n = ST_LOAD;
            else                 state_n = ST_IDLE;
         end
         ST_LOAD:  state_n = ST_SHIFT;
         ST_SHIFT: begin
            if (cnt_r == 4'd8) state_n = ST_DONE;
            else               state_n = ST_SHIFT;
         end
         ST_DONE:  state_n = ST_IDLE;
         default:  state_n = ST_IDLE;
      endcase
   end

   // Converter datapath: source is frozen at start, digits only written in DONE
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_r     <= 9'd0;
         conv_src_r <= 9'd0;
         shift_r    <= 21'd0;
         cnt_r      <= 4'd0;
         hund_r     <= 4'd0;
         tens_r     <= 4'd0;
         units_r    <= 4'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (state_n == ST_LOAD) begin
                  conv_src_r <= src_s;
                  last_r     <= src_s;
               end
            end
            ST_LOAD: begin
               shift_r <= {12'd0, conv_src_r};
               cnt_r   <= 4'd0;
            end
            ST_SHIFT: begin
               shift_r <= bcd_step(shift_r);
               cnt_r   <= cnt_r + 4'd1;
            end
            ST_DONE: begin
               hund_r  <= shift_r[20:17];
               tens_r  <= shift_r[16:13];
               units_r <= shift_r[12:9];
            end
            default: begin
               cnt_r <= 4'd0;
            end
         endcase
      end
   end

   // Digit enable for the slot being scanned
   always_comb begin
      an_s = 4'hF;
      case (digit_r)
         2'd0:    an_s = 4'b1110;
         2'd1:    an_s = 4'b1101;
         2'd2:    an_s = 4'b1011;
         2'd3:    an_s = 4'b0111;
         default: an_s = 4'hF;
      endcase
   end

   // Segment pattern for the slot: hundreds/tens/units with leading blanks, then status
   always_comb begin
      seg_s = 7'h7F;
      case (digit_r)
         2'd3: begin
            if (hund_r == 4'd0) seg_s = 7'h7F;
            else                seg_s = digit_glyph(hund_r);
         end
         2'd2: begin
            if (hund_r == 4'd0 && tens_r == 4'd0) seg_s = 7'h7F;
            else                                  seg_s = digit_glyph(tens_r);
         end
         2'd1: seg_s = digit_glyph(units_r);
         2'd0: begin
            if (rv_r) begin
               if (winner_r) seg_s = digit_glyph(4'd2);
               else          seg_s = digit_glyph(4'd1);
            end else if (sb.disp_sel) begin
               seg_s = 7'h7F;
            end else if (sb.wickets >= 4'd10) begin
               seg_s = 7'b0111111;
            end else begin
               seg_s = digit_glyph(sb.wickets);
            end
         end
         default: seg_s = 7'h7F;
      endcase
   end

   // Scan divider and registered an/seg so both change on the same edge
   always_ff @(posedge clk) begin
      if (!reset) begin
         scan_cnt_r <= 16'd0;
         digit_r    <= 2'd0;
         an_r       <= 4'hF;
         seg_r      <= 7'h7F;
      end else begin
         if (scan_cnt_r == SCAN_LAST) begin
            scan_cnt_r <= 16'd0;
            digit_r    <= digit_r + 2'd1;
         end else begin
            scan_cnt_r <= scan_cnt_r + 16'd1;
         end
         an_r  <= an_s;
         seg_r <= seg_s;
      end
   end

   assign sb.target       = target_r;
   assign sb.innings      = innings_r;
   assign sb.result_valid = rv_r;
   assign sb.bcd_busy     = busy_r;
   assign sb.an           = an_r;
   assign sb.seg          = seg_r;

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Self-checking bench for scoreboard_ctrl: directed steps plus random scores,
// checked against a decimal-arithmetic model of the display and match state.
module tb_scoreboard_ctrl;
   localparam int SD = 4;

   logic clk = 1'b0;
   logic reset = 1'b0;
   scoreboard_ctrl_if sb ();

   scoreboard_ctrl #(.SCAN_DIV(SD)) dut (.clk(clk), .reset(reset), .sb(sb));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [8:0] m_target;
   bit         m_rv, m_winner;

   logic [6:0] gl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                            7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [6:0] exp_seg(input int idx);
      int v, h, t, u;
      v = sb.disp_sel ? int'(m_target) : int'(sb.runs);
      h = v / 100;
      t = (v / 10) % 10;
      u = v % 10;
      case (idx)
         3: return (h == 0) ? 7'h7F : gl[h];
         2: return (h == 0 && t == 0) ? 7'h7F : gl[t];
         1: return gl[u];
         default: begin
            if (m_rv) return m_winner ? gl[2] : gl[1];
            if (sb.disp_sel) return 7'h7F;
            if (sb.wickets >= 4'd10) return 7'b0111111;
            return gl[sb.wickets];
         end
      endcase
   endfunction

   // Wait until the converter has been quiet for three samples in a row
   task automatic settle();
      int quiet = 0;
      int k = 0;
      step(2);
      while (quiet < 3 && k < 100) begin
         step(1);
         k++;
         if (sb.bcd_busy === 1'b0) quiet++;
         else quiet = 0;
      end
      chk("settle_quiet", quiet, 3);
      step(2);
   endtask

   task automatic check_display(input string tag);
      int idx;
      logic [3:0] seen = 4'h0;
      for (int k = 0; k < 4 * SD + 2; k++) begin
         step(1);
         case (sb.an)
            4'b1110: idx = 0;
            4'b1101: idx = 1;
            4'b1011: idx = 2;
            4'b0111: idx = 3;
            default: idx = -1;
         endcase
         chk({tag, "_an_onehot"}, (idx >= 0), 1);
         if (idx >= 0) begin
            chk({tag, "_seg"}, sb.seg, exp_seg(idx));
            seen[idx] = 1'b1;
         end
      end
      chk({tag, "_all_digits"}, seen, 4'hF);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cnt;
      logic [7:0] vals [$];
      m_target = 9'd0; m_rv = 1'b0; m_winner = 1'b0;
      sb.runs = 8'd0; sb.wickets = 4'd0; sb.inning_over = 1'b0;
      sb.game_over = 1'b0; sb.winner = 1'b0; sb.disp_sel = 1'b0;

      // Reset state
      step(3);
      chk("rst_target", sb.target, 9'd0);
      chk("rst_innings", sb.innings, 1'b0);
      chk("rst_rv", sb.result_valid, 1'b0);
      chk("rst_busy", sb.bcd_busy, 1'b0);
      chk("rst_an", sb.an, 4'hF);
      chk("rst_seg", sb.seg, 7'h7F);
      reset = 1'b1;

      // Zero score: no conversion, display "  0" with wickets 0
      for (int k = 0; k < 6; k++) begin
         step(1);
         chk("idle_no_conv", sb.bcd_busy, 1'b0);
      end
      check_display("zero");

      // 0 -> 147: converter busy for exactly 11 cycles
      sb.runs = 8'd147;
      busy_cnt = 0;
      for (int k = 0; k < 40; k++) begin
         step(1);
         if (sb.bcd_busy === 1'b1) busy_cnt++;
      end
      chk("busy_len", busy_cnt, 11);
      check_display("r147");

      // Boundary then random scores; odd entries change runs mid-conversion
      vals = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd200};
      for (int i = 0; i < 8; i++) vals.push_back(8'($urandom_range(0, 255)));
      foreach (vals[i]) begin
         sb.runs = vals[i];
         sb.wickets = 4'($urandom_range(0, 11));
         if (i % 2 == 1) begin
            step(4);
            sb.runs = 8'($urandom_range(0, 255));
         end
         settle();
         check_display("score");
      end

      // First innings closes at 255 -> target 256
      sb.runs = 8'd255; sb.wickets = 4'd3;
      settle();
      sb.inning_over = 1'b1;
      step(4);
      m_target = 9'd256;
      chk("tgt_256", sb.target, 9'd256);
      chk("innings_1", sb.innings, 1'b1);
      sb.inning_over = 1'b0;
      sb.disp_sel = 1'b1;
      settle();
      check_display("show_tgt");

      // Second inning_over edge leaves the target alone
      sb.runs = 8'd30;
      step(2);
      sb.inning_over = 1'b1;
      step(4);
      chk("tgt_hold", sb.target, 9'd256);
      chk("innings_hold", sb.innings, 1'b1);
      sb.inning_over = 1'b0;
      check_display("tgt_hold");

      // All out: dash in the wickets slot
      sb.disp_sel = 1'b0; sb.wickets = 4'd10;
      settle();
      check_display("wk10");

      // Result: team B wins, later changes cannot alter anything
      sb.winner = 1'b1; sb.game_over = 1'b1;
      step(4);
      m_rv = 1'b1; m_winner = 1'b1;
      chk("rv_set", sb.result_valid, 1'b1);
      check_display("win_b");
      sb.winner = 1'b0;
      step(2);
      check_display("win_b_toggle");
      sb.disp_sel = 1'b1;
      settle();
      check_display("win_b_tgt");
      sb.game_over = 1'b0;
      step(3);
      sb.game_over = 1'b1; sb.inning_over = 1'b1; sb.runs = 8'd77;
      step(4);
      chk("frozen_tgt", sb.target, 9'd256);
      chk("frozen_inn", sb.innings, 1'b1);
      chk("frozen_rv", sb.result_valid, 1'b1);
      check_display("frozen");

      // Reset in the middle of a conversion
      sb.disp_sel = 1'b0; sb.runs = 8'd123;
      step(4);
      chk("mid_shift_busy", sb.bcd_busy, 1'b1);
      reset = 1'b0; sb.inning_over = 1'b0; sb.game_over = 1'b0;
      step(1);
      m_target = 9'd0; m_rv = 1'b0; m_winner = 1'b0;
      chk("rst2_target", sb.target, 9'd0);
      chk("rst2_innings", sb.innings, 1'b0);
      chk("rst2_rv", sb.result_valid, 1'b0);
      chk("rst2_busy", sb.bcd_busy, 1'b0);
      chk("rst2_an", sb.an, 4'hF);
      chk("rst2_seg", sb.seg, 7'h7F);
      step(2);
      reset = 1'b1;
      for (int k = 0; k < 4 * SD + 4; k++) begin
         logic [3:0] exp_an;
         step(1);
         exp_an = ~(4'b0001 << ((k / SD) % 4));
         chk("scan_after_rst", sb.an, exp_an);
      end
      settle();
      check_display("post_rst");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
